wm8731_adc_ctrl: RTL
====================

Name: wm8731_adc_ctrl

Overview:
- Master-side sequencer for the WM8731 ADC serial port, clocked from m_clk.
- Generates b_clk and adc_lr_clk, then deserialises adcdat MSB-first into left and right sample words.
- Presents each stereo pair to the downstream datapath over a valid/ready handshake, with a sticky overrun flag.
- Sits between the codec pins (or the codec functional model in simulation) and the audio processing chain.

Parameters:
- BCLK_DIV, 4: m_clk cycles per b_clk half-period; legal range 2..255.
- SLOT_BITS, 32: b_clk cycles per channel slot; legal range 16..32.
- SAMPLE_BITS, 24: bits captured per channel from the start of each slot; must be 16..SLOT_BITS.

Ports:
- m_clk  in  1  master clock, the only clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run request, sampled every cycle.
- adcdat  in  1  serial ADC data from the codec; changes after b_clk rises.
- b_clk  out  1  bit clock, registered.
- adc_lr_clk  out  1  frame clock, registered; 1 = left slot, 0 = right slot.
- left_data  out  SAMPLE_BITS  last captured left sample.
- right_data  out  SAMPLE_BITS  last captured right sample.
- sample_valid  out  1  left_data/right_data hold an unconsumed pair.
- sample_ready  in  1  consumer accepts the pair.
- overrun  out  1  sticky: a pair was overwritten before it was accepted.
- overrun_clr  in  1  clears overrun.
- busy  out  1  high in LEFT or RIGHT state.

Behaviour:
- Reset (asynchronous): state IDLE. b_clk, adc_lr_clk, sample_valid, overrun and busy are 0. left_data and right_data are 0. div_cnt, bit_cnt and the shift register are 0.
- States and transitions:
  - IDLE to LEFT on enable=1. On that edge adc_lr_clk goes to 1; b_clk, div_cnt and bit_cnt are 0.
  - LEFT to RIGHT on the SLOT_BITS-th b_clk falling edge. adc_lr_clk goes to 0 on that same edge.
  - RIGHT to LEFT on the 2*SLOT_BITS-th falling edge if enable=1; adc_lr_clk goes to 1 on that edge.
  - RIGHT to IDLE on that same edge if enable=0; b_clk and adc_lr_clk are then held at 0.
  - Deasserting enable mid-frame has no effect until the frame boundary; frames are never truncated.
- Clock generation:
  - div_cnt counts 0..BCLK_DIV-1 in LEFT and RIGHT.
  - At BCLK_DIV-1, b_clk toggles and div_cnt wraps to 0.
  - b_clk period is 2*BCLK_DIV m_clk cycles. The first b_clk rise comes BCLK_DIV cycles after entering LEFT.
  - adc_lr_clk changes only coincident with a b_clk falling edge.
- Capture:
  - On the m_clk edge where b_clk goes from 1 to 0 ("fall edge"), adcdat is sampled and bit_cnt increments, wrapping at 2*SLOT_BITS.
  - Slot bit index = bit_cnt mod SLOT_BITS. Indices 0..SAMPLE_BITS-1 shift into the shift register LSB-in, so the first bit ends up as the MSB. Higher indices are ignored.
  - At the end of the left slot, the shift register transfers to an internal left holding register.
  - At the end of the right slot, left_data is loaded from the holding register and right_data from the shift register. sample_valid is set on the same edge.
  - There are no gaps between frames: 2*SLOT_BITS*2*BCLK_DIV m_clk cycles per frame.
- Handshake:
  - A transfer occurs on any edge where sample_valid=1 and sample_ready=1; sample_valid clears on the next edge.
  - Data is stable while sample_valid=1, except on overwrite.
  - If a frame completes while sample_valid=1 and no transfer happens on that edge, the data is overwritten, sample_valid stays 1 and overrun is set.
  - If a transfer and a frame completion fall on the same edge, the new pair loads, sample_valid stays 1 and overrun is not set.
- overrun_clr clears overrun. If a clear and a set fall on the same edge, set wins.
- busy is 1 in LEFT and RIGHT.
- Reset mid-frame returns everything to the reset values immediately; the partial frame is discarded.

Test Plan:
- Reset then enable=1 with BCLK_DIV=4 -> adc_lr_clk=1 after one edge; first b_clk rise at cycle 4; b_clk period 8 cycles; adc_lr_clk falls at cycle 256 and rises at cycle 512.
- Codec model drives left slot 0xA5C3_F00F and right slot 0x1234_5678 (SAMPLE_BITS=24), sample_ready=1 -> left_data=0xA5C3F0, right_data=0x123456, sample_valid pulses 1 cycle at frame end.
- Hold sample_ready=0 for two frames -> sample_valid stays 1, data equals the second frame, overrun=1. Then overrun_clr=1 -> overrun=0.
- sample_ready=1 coincident with the frame-completion edge while valid -> new data loaded, overrun stays 0.
- enable dropped at cycle 100 of a frame -> frame completes, the pair is delivered, then IDLE with b_clk=0, adc_lr_clk=0 and busy=0.
- rst pulsed mid-right-slot -> all outputs 0 asynchronously. After re-enable, the next frame captures correctly and has no residue from the aborted frame.

Source files
------------

// File: rtl/wm8731_adc_ctrl.sv
// wm8731_adc_ctrl
// Master-side sequencer for the WM8731 ADC serial port. It derives b_clk and
// adc_lr_clk from m_clk, shifts adcdat in MSB-first on every b_clk falling
// edge, and presents each completed stereo pair over a valid/ready handshake
// with a sticky overrun flag.
//
// Ports:
//   m_clk        master clock, all logic on its rising edge
//   rst          asynchronous active-high reset
//   enable       run request; only acted on at frame boundaries once running
//   adcdat       serial data from the codec (changes after b_clk rises)
//   b_clk        registered bit clock, period 2*BCLK_DIV m_clk cycles
//   adc_lr_clk   registered frame clock, 1 = left slot, 0 = right slot
//   left_data    last captured left sample
//   right_data   last captured right sample
//   sample_valid left_data/right_data hold an unconsumed pair
//   sample_ready consumer accepts the pair
//   overrun      sticky: a pair was overwritten before it was accepted
//   overrun_clr  clears overrun (a simultaneous set wins)
//   busy         high while a frame is in progress
module wm8731_adc_ctrl #(
  parameter int BCLK_DIV    = 4,
  parameter int SLOT_BITS   = 32,
  parameter int SAMPLE_BITS = 24
) (
  input  logic                   m_clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   adcdat,
  output logic                   b_clk,
  output logic                   adc_lr_clk,
  output logic [SAMPLE_BITS-1:0] left_data,
  output logic [SAMPLE_BITS-1:0] right_data,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   overrun,
  input  logic                   overrun_clr,
  output logic                   busy
);

  localparam int CNT_W = $clog2(2 * SLOT_BITS);
  localparam logic [7:0]       DIV_MAX    = 8'(BCLK_DIV - 1);
  localparam logic [CNT_W-1:0] SLOT_W     = CNT_W'(SLOT_BITS);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(2 * SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] SAMPLE_W   = CNT_W'(SAMPLE_BITS);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

  state_t                 state_reg, state_next;
  logic [7:0]             div_cnt_reg;
  logic [CNT_W-1:0]       bit_cnt_reg;
  logic [SAMPLE_BITS-1:0] shift_reg;
  logic [SAMPLE_BITS-1:0] shift_next;
  logic [SAMPLE_BITS-1:0] left_hold_reg;
  logic [CNT_W-1:0]       slot_idx;
  logic                   div_last;
  logic                   fall_edge;
  logic                   left_end;
  logic                   right_end;
  logic                   transfer;

  // Datapath decode shared by the FSM and the registers.
  always_comb begin
    div_last  = (state_reg != IDLE) && (div_cnt_reg == DIV_MAX);
    // The edge on which b_clk is about to go 1 -> 0 is the capture edge.
    fall_edge = div_last && b_clk;
    slot_idx  = (bit_cnt_reg >= SLOT_W) ? (bit_cnt_reg - SLOT_W) : bit_cnt_reg;
    left_end  = fall_edge && (state_reg == LEFT)  && (bit_cnt_reg == SLOT_LAST);
    right_end = fall_edge && (state_reg == RIGHT) && (bit_cnt_reg == FRAME_LAST);
    transfer  = sample_valid && sample_ready;
    // Bits beyond SAMPLE_BITS in a slot are ignored. The shifted value is used
    // directly at slot ends so a bit captured on the last edge is not lost.
    shift_next = shift_reg;
    if (fall_edge && (slot_idx < SAMPLE_W))
      shift_next = {shift_reg[SAMPLE_BITS-2:0], adcdat};
  end

  // FSM: state register
  always_ff @(posedge m_clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FSM: next state. enable is only looked at in IDLE and at the end of a
  // frame, so frames are never truncated.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (enable)    state_next = LEFT;
      LEFT:    if (left_end)  state_next = RIGHT;
      RIGHT:   if (right_end) state_next = enable ? LEFT : IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_reg == LEFT) || (state_reg == RIGHT);
  end

  // Clock generation, capture and handshake registers.
  always_ff @(posedge m_clk or posedge rst) begin
    if (rst) begin
      div_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      left_hold_reg <= '0;
      b_clk         <= 1'b0;
      adc_lr_clk    <= 1'b0;
      left_data     <= '0;
      right_data    <= '0;
      sample_valid  <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (state_reg == IDLE) begin
        div_cnt_reg <= '0;
        bit_cnt_reg <= '0;
        b_clk       <= 1'b0;
        adc_lr_clk  <= enable;
      end else begin
        if (div_last) begin
          div_cnt_reg <= '0;
          b_clk       <= ~b_clk;
        end else begin
          div_cnt_reg <= div_cnt_reg + 8'd1;
        end
        if (fall_edge) begin
          bit_cnt_reg <= (bit_cnt_reg == FRAME_LAST) ? '0 : bit_cnt_reg + CNT_W'(1);
          shift_reg   <= shift_next;
        end
        if (left_end) begin
          left_hold_reg <= shift_next;
          adc_lr_clk    <= 1'b0;
        end
        if (right_end) begin
          left_data  <= left_hold_reg;
          right_data <= shift_next;
          // Falls back to 0 when the sequencer returns to IDLE.
          adc_lr_clk <= enable;
        end
      end

      // A frame completion always (re)asserts valid; a transfer alone clears it.
      if (right_end)     sample_valid <= 1'b1;
      else if (transfer) sample_valid <= 1'b0;

      if (right_end && sample_valid && !sample_ready) overrun <= 1'b1;
      else if (overrun_clr)                           overrun <= 1'b0;
    end
  end

endmodule
